// File: rtl/rs_issue_scheduler.sv
// Reservation station between dispatch and one FU: buffers packets, wakes sources on tag broadcast,
// issues oldest-ready; 1-cycle dispatch/wakeup-to-issue; disp_ready from occupancy, iss held under iss_ready=0.
package CORE_PKG;
   parameter int RS_ENTRIES = 4;
   parameter int NUM_PREGS  = 64;
   localparam int PW = $clog2(NUM_PREGS);

   typedef struct packed {
      logic [PW-1:0] dst_preg;
      logic [PW-1:0] src1_preg;
      logic [PW-1:0] src2_preg;
      logic [31:0]   imm;
      logic          instr_valid;
      logic [31:0]   pc;
   } disp_packet_t;
endpackage

module rs_issue_scheduler #(
   parameter int RS_ENTRIES = CORE_PKG::RS_ENTRIES,
   parameter int NUM_PREGS  = CORE_PKG::NUM_PREGS,
   parameter int NUM_WB     = 2,
   localparam int PW        = $clog2(NUM_PREGS),
   localparam int CW        = $clog2(RS_ENTRIES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  CORE_PKG::disp_packet_t     disp_packet,
   input  logic                       disp_src1_rdy,
   input  logic                       disp_src2_rdy,
   input  logic [NUM_WB-1:0]          wb_valid,
   input  logic [NUM_WB*PW-1:0]       wb_preg,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output CORE_PKG::disp_packet_t     iss_packet,
   output logic [CW-1:0]              rs_count
);
   localparam int IW = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

   logic [RS_ENTRIES-1:0]  ent_vld;
   logic [RS_ENTRIES-1:0]  ent_s1;
   logic [RS_ENTRIES-1:0]  ent_s2;
   CORE_PKG::disp_packet_t ent_pkt [RS_ENTRIES];
   // older[i][j] is set when entry i was dispatched before entry j
   logic [RS_ENTRIES-1:0]  older [RS_ENTRIES];
   logic [CW-1:0]          count;

   logic [RS_ENTRIES-1:0]  wake1;
   logic [RS_ENTRIES-1:0]  wake2;
   logic                   disp_w1;
   logic                   disp_w2;
   logic [RS_ENTRIES-1:0]  ready;
   logic [RS_ENTRIES-1:0]  sel_oh;
   logic [IW-1:0]          sel_idx;
   logic [IW-1:0]          free_idx;
   logic                   free_found;
   logic                   disp_fire;
   logic                   iss_fire;

   always_comb begin
      wake1   = '0;
      wake2   = '0;
      disp_w1 = 1'b0;
      disp_w2 = 1'b0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_valid[k]) begin
            if (wb_preg[k*PW +: PW] == disp_packet.src1_preg) disp_w1 = 1'b1;
            if (wb_preg[k*PW +: PW] == disp_packet.src2_preg) disp_w2 = 1'b1;
            for (int i = 0; i < RS_ENTRIES; i++) begin
               if (wb_preg[k*PW +: PW] == ent_pkt[i].src1_preg) wake1[i] = 1'b1;
               if (wb_preg[k*PW +: PW] == ent_pkt[i].src2_preg) wake2[i] = 1'b1;
            end
         end
      end
   end

   assign ready = ent_vld & ent_s1 & ent_s2;

   // An entry wins when no other ready entry is older than it; ages are unique.
   always_comb begin
      sel_oh  = ready;
      sel_idx = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         for (int j = 0; j < RS_ENTRIES; j++) begin
            if (j != i && ready[j] && older[j][i]) sel_oh[i] = 1'b0;
         end
      end
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (sel_oh[i]) sel_idx = IW'(i);
      end
   end

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (!ent_vld[i] && !free_found) begin
            free_idx   = IW'(i);
            free_found = 1'b1;
         end
      end
   end

   assign disp_ready = (count < CW'(RS_ENTRIES));
   assign rs_count   = count;
   assign iss_valid  = |ready;
   assign iss_packet = iss_valid ? ent_pkt[sel_idx] : '0;
   assign disp_fire  = disp_valid && disp_ready && !flush;
   assign iss_fire   = iss_valid && iss_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_vld <= '0;
         ent_s1  <= '0;
         ent_s2  <= '0;
         count   <= '0;
      end else if (flush) begin
         ent_vld <= '0;
         count   <= '0;
      end else begin
         ent_s1 <= ent_s1 | wake1;
         ent_s2 <= ent_s2 | wake2;
         if (iss_fire) ent_vld[sel_idx] <= 1'b0;
         // free_idx is never the selected slot, so issue and dispatch cannot collide
         if (disp_fire) begin
            ent_vld[free_idx] <= 1'b1;
            ent_pkt[free_idx] <= disp_packet;
            ent_s1[free_idx]  <= disp_src1_rdy | disp_w1;
            ent_s2[free_idx]  <= disp_src2_rdy | disp_w2;
            for (int i = 0; i < RS_ENTRIES; i++) begin
               for (int j = 0; j < RS_ENTRIES; j++) begin
                  if (IW'(i) == free_idx)      older[i][j] <= 1'b0;
                  else if (IW'(j) == free_idx) older[i][j] <= 1'b1;
               end
            end
         end
         count <= count + CW'(disp_fire) - CW'(iss_fire);
      end
   end
endmodule
